hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage RV64 core. It drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX, and freezes the whole pipe. It resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits under one FSM. It sits in the ID stage, reading the ID/EX register outputs and the EX/MEM branch result.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and constants for the pipeline hazard controller.
//   state_t    : controller states (RUN, LOAD_STALL, BR_FLUSH, MEM_WAIT)
//   ZERO_REG   : register x0, never a real data dependency
//   CNT_LOAD_W : width of the stall/flush down-counter
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam logic [4:0] ZERO_REG   = 5'd0;
    localparam int         CNT_LOAD_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Purely combinational load-use hazard compare. Flags when the load sitting
// in ID/EX writes a register that the instruction in IF/ID reads.
// Ports:
//   rs1, rs2  : source register fields of the IF/ID instruction
//   rd        : destination register of the ID/EX instruction
//   mem_read  : ID/EX instruction is a load
//   hit       : load-use dependency present
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] rd,
    input  logic       mem_read,
    output logic       hit
);

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign hit = mem_read && (rd != ZERO_REG) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. Resolves load-use
// stalls, taken-branch flushes and data-memory waits under one FSM, with
// Mealy outputs valid in the same cycle as the hazard.
// Optional feature: define HAZARD_PERF_CNT_EN to add the saturating
// Stall_Count / Flush_Count performance counters and their ports.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   IFID_RS1, IFID_RS2      : source fields of the IF/ID instruction
//   IDEX_RD, IDEX_MemRead   : destination and load flag of ID/EX
//   Branch_Taken            : taken branch/jump resolved in EX/MEM
//   Mem_Busy                : data memory not ready
//   PC_Write, IFID_Write    : PC and IF/ID load enables
//   IFID_Flush, IDEX_Bubble : IF/ID NOP insert, ID/EX control bubble
//   Pipe_Freeze             : hold ID/EX, EX/MEM and MEM/WB
//   Stall_Count, Flush_Count: performance counters (HAZARD_PERF_CNT_EN only)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IFID_RS1,
    input  logic [4:0] IFID_RS2,
    input  logic [4:0] IDEX_RD,
    input  logic       IDEX_MemRead,
    input  logic       Branch_Taken,
    input  logic       Mem_Busy,
    output logic       PC_Write,
    output logic       IFID_Write,
    output logic       IFID_Flush,
    output logic       IDEX_Bubble,
    output logic       Pipe_Freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
`endif
);

    localparam logic [CNT_LOAD_W-1:0] LOAD_INIT  = CNT_LOAD_W'(LOAD_LAT - 1);
    localparam logic [CNT_LOAD_W-1:0] FLUSH_INIT = CNT_LOAD_W'(FLUSH_CYCLES - 1);

    state_t                state;
    state_t                ret;
    state_t                cur_state;
    state_t                next_state;
    logic [CNT_LOAD_W-1:0] cnt;
    logic [CNT_LOAD_W-1:0] ret_cnt;
    logic [CNT_LOAD_W-1:0] cur_cnt;
    logic [CNT_LOAD_W-1:0] next_cnt;
    logic                  hit;

    load_use_detect u_detect (
        .rs1      (IFID_RS1),
        .rs2      (IFID_RS2),
        .rd       (IDEX_RD),
        .mem_read (IDEX_MemRead),
        .hit      (hit)
    );

    // When a memory wait ends, the saved state is restored and its rules
    // apply in that same cycle, so decode works on the "effective" state.
    always_comb begin
        cur_state = state;
        cur_cnt   = cnt;
        if (state == MEM_WAIT && !Mem_Busy) begin
            cur_state = ret;
            cur_cnt   = ret_cnt;
        end
    end

    // Output and next-state decode. Priority: reset, memory wait, taken
    // branch (also abandons a load stall or restarts a flush), then the
    // per-state stall/flush rules.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        Pipe_Freeze = 1'b0;
        next_state  = cur_state;
        next_cnt    = cur_cnt;

        if (reset) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            next_state  = RUN;
            next_cnt    = '0;
        end else if (Mem_Busy) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
            next_state  = MEM_WAIT;
            next_cnt    = cnt;
        end else if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                next_state = BR_FLUSH;
                next_cnt   = FLUSH_INIT;
            end else begin
                next_state = RUN;
                next_cnt   = '0;
            end
        end else begin
            case (cur_state)
                RUN: begin
                    if (hit) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            next_state = LOAD_STALL;
                            next_cnt   = LOAD_INIT;
                        end
                    end
                end
                LOAD_STALL: begin
                    PC_Write    = 1'b0;
                    IFID_Write  = 1'b0;
                    IDEX_Bubble = 1'b1;
                    if (cur_cnt == CNT_LOAD_W'(1)) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cur_cnt - CNT_LOAD_W'(1);
                    end
                end
                BR_FLUSH: begin
                    IFID_Flush  = 1'b1;
                    IDEX_Bubble = 1'b1;
                    if (cur_cnt == CNT_LOAD_W'(1)) begin
                        next_state = RUN;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cur_cnt - CNT_LOAD_W'(1);
                    end
                end
                default: begin
                    next_state = RUN;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // State registers. The return state is captured only on entry to
    // MEM_WAIT so a long wait keeps the state that was interrupted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            cnt     <= '0;
            ret     <= RUN;
            ret_cnt <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (Mem_Busy && state != MEM_WAIT) begin
                ret     <= state;
                ret_cnt <= cnt;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters: stalled cycles (PC held) and flush cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (!PC_Write && Stall_Count != {CNT_W{1'b1}}) begin
                Stall_Count <= Stall_Count + CNT_W'(1);
            end
            if (IFID_Flush && Flush_Count != {CNT_W{1'b1}}) begin
                Flush_Count <= Flush_Count + CNT_W'(1);
            end
        end
    end
`endif

endmodule
